// File: rtl/matrix_host_driver.sv
// Host-side sequencer for a streaming matrix multiplier.
// It loads A then B from upstream, streams them to the multiplier, captures the
// M*M result stream and hands it downstream with a valid/ready handshake.
module matrix_host_driver #(
  parameter int unsigned DW      = 8,
  parameter int unsigned M       = 8,
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mm_start,
  output logic [DW-1:0] mm_data_in,
  input  logic [DW-1:0] mm_data_out,
  input  logic          mm_done,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  localparam int unsigned DEPTH = 2 * M * N;
  localparam int unsigned RES_N = M * M;
  localparam int unsigned CMAX  = (DEPTH > RES_N) ? DEPTH : RES_N;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned RW    = (RES_N > 1) ? $clog2(RES_N) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COLLECT = 3'd5;
  localparam logic [2:0] S_UNLOAD  = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          in_ready_q, in_ready_d;
  logic          mm_start_q, mm_start_d;
  logic [DW-1:0] mm_data_in_q, mm_data_in_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [DW-1:0] op_mem  [DEPTH];
  logic [DW-1:0] res_mem [RES_N];

  logic          op_we_c;
  logic [AW-1:0] op_wa_c;
  logic          res_we_c;
  logic [RW-1:0] res_wa_c;

  // Next state, counters, storage write strobes and the registered outputs' next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    op_we_c  = 1'b0;
    op_wa_c  = '0;
    res_we_c = 1'b0;
    res_wa_c = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_we_c = 1'b1;
          op_wa_c = '0;
          cnt_d   = CW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          op_we_c = 1'b1;
          op_wa_c = AW'(cnt_q);
          if (cnt_q == CW'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (cnt_q == CW'(DEPTH - 1)) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (mm_done) begin
          res_we_c = 1'b1;
          res_wa_c = '0;
          tcnt_d   = '0;
          if (RES_N == 1) begin
            cnt_d   = '0;
            state_d = S_UNLOAD;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_COLLECT;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          tcnt_d  = TW'(TIMEOUT);
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_COLLECT: begin
        res_we_c = 1'b1;
        res_wa_c = RW'(cnt_q);
        if (cnt_q == CW'(RES_N - 1)) begin
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == CW'(RES_N - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tcnt_d  = '0;
      end
    endcase

    // Outputs are a registered image of the next state
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    mm_start_d  = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    err_d       = (state_d == S_ERR);
    out_valid_d = (state_d == S_UNLOAD);

    mm_data_in_d = '0;
    if (state_d == S_STREAM) begin
      mm_data_in_d = op_mem[AW'(cnt_d)];
    end

    // Bypass covers the result element being written on the same edge
    out_data_d = '0;
    if (state_d == S_UNLOAD) begin
      if (res_we_c && (res_wa_c == RW'(cnt_d))) begin
        out_data_d = mm_data_out;
      end else begin
        out_data_d = res_mem[RW'(cnt_d)];
      end
    end
  end

  // State, counters and registered outputs with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      in_ready_q   <= 1'b1;
      mm_start_q   <= 1'b0;
      mm_data_in_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      in_ready_q   <= in_ready_d;
      mm_start_q   <= mm_start_d;
      mm_data_in_q <= mm_data_in_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Operand and result storage; contents survive reset
  always_ff @(posedge clk) begin
    if (op_we_c) begin
      op_mem[op_wa_c] <= in_data;
    end
    if (res_we_c) begin
      res_mem[res_wa_c] <= mm_data_out;
    end
  end

  assign in_ready   = in_ready_q;
  assign mm_start   = mm_start_q;
  assign mm_data_in = mm_data_in_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matrix_host_driver.sv
// Self-checking bench for matrix_host_driver (M=N=2, TIMEOUT=16).
// The bench plays upstream, multiplier and downstream; expected streams come
// from the loaded operands and a plain-arithmetic matrix product.
module tb_matrix_host_driver;

  localparam int DW = 8;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int TO = 16;
  localparam int NE = 2 * M * N;
  localparam int NR = M * M;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mm_start;
  logic [DW-1:0] mm_data_in;
  logic [DW-1:0] mm_data_out = '0;
  logic          mm_done = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          err;

  logic [DW-1:0] cur_el [NE];
  logic [DW-1:0] cur_c  [NR];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matrix_host_driver #(.DW(DW), .M(M), .N(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mm_start    (mm_start),
    .mm_data_in  (mm_data_in),
    .mm_data_out (mm_data_out),
    .mm_done     (mm_done),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product C = A * B, truncated to DW bits
  task automatic compute_c();
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) begin
          acc += int'(cur_el[i*N + k]) * int'(cur_el[M*N + k*M + j]);
        end
        cur_c[i*M + j] = DW'(acc);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   1);
    chk({tag, "_mm_start"},   32'(mm_start),   0);
    chk({tag, "_mm_data_in"}, 32'(mm_data_in), 0);
    chk({tag, "_out_valid"},  32'(out_valid),  0);
    chk({tag, "_out_data"},   32'(out_data),   0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_err"},        32'(err),        0);
  endtask

  // Upstream load with random gaps; optional spurious mm_done pulses
  task automatic load_phase(input bit noise);
    int i = 0;
    int guard = 0;
    while (i < NE && guard < 200) begin
      guard++;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? cur_el[i] : DW'($urandom);
      if (noise) mm_done = ($urandom_range(0, 1) == 1);
      mm_data_out = DW'($urandom);
      chk("in_ready_load", 32'(in_ready), 1);
      tick();
      if (in_valid) i++;
    end
    in_valid = 1'b0;
    mm_done  = 1'b0;
    chk("load_count", 32'(i), NE);
    chk("mm_start_pulse", 32'(mm_start), 1);
    chk("in_ready_start", 32'(in_ready), 0);
    chk("busy_start", 32'(busy), 1);
  endtask

  // Expect the first n operand elements on consecutive cycles after mm_start
  task automatic stream_phase(input bit noise, input int n);
    if (noise) in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (noise) in_data = DW'($urandom);
      tick();
      chk("mm_data_in", 32'(mm_data_in), 32'(cur_el[i]));
      chk("mm_start_low", 32'(mm_start), 0);
      chk("in_ready_stream", 32'(in_ready), 0);
    end
    if (n == NE) begin
      in_valid = 1'b0;
      tick();
      chk("mm_data_in_after", 32'(mm_data_in), 0);
    end
  endtask

  // Multiplier model: done after d idle cycles, then results back to back
  task automatic respond_phase(input int d);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("out_valid_wait", 32'(out_valid), 0);
    end
    mm_done     = 1'b1;
    mm_data_out = cur_c[0];
    tick();
    for (int j = 1; j < NR; j++) begin
      mm_done = ($urandom_range(0, 1) == 1);
      chk("out_valid_collect", 32'(out_valid), 0);
      mm_data_out = cur_c[j];
      tick();
    end
    mm_done     = 1'b0;
    mm_data_out = DW'($urandom);
  endtask

  // Downstream: mode 0 random ready, 1 pattern 1,0,0,1, 2 always ready
  task automatic unload_phase(input int mode);
    logic [DW-1:0] q[$];
    int pat [4] = '{1, 0, 0, 1};
    int cycles = 0;
    for (int j = 0; j < NR; j++) q.push_back(cur_c[j]);
    while (q.size() > 0 && cycles < 64) begin
      case (mode)
        0:       out_ready = ($urandom_range(0, 1) == 1);
        1:       out_ready = (pat[cycles % 4] != 0);
        default: out_ready = 1'b1;
      endcase
      chk("out_valid_unload", 32'(out_valid), 1);
      chk("out_data", 32'(out_data), 32'(q[0]));
      tick();
      if (out_ready) void'(q.pop_front());
      cycles++;
    end
    out_ready = 1'b0;
    chk("unload_drained", 32'(q.size()), 0);
    if (mode == 2) chk("unload_cycles", 32'(cycles), NR);
    chk("busy_end", 32'(busy), 0);
    chk("out_valid_end", 32'(out_valid), 0);
    chk("in_ready_end", 32'(in_ready), 1);
  endtask

  task automatic full_txn(input bit noise, input int d, input int mode);
    compute_c();
    load_phase(noise);
    stream_phase(noise, NE);
    respond_phase(d);
    unload_phase(mode);
  endtask

  task automatic set_directed();
    for (int i = 0; i < NE; i++) cur_el[i] = DW'(i + 1);
  endtask

  task automatic set_random();
    for (int i = 0; i < NE; i++) cur_el[i] = DW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_reset_vals("idle");

    // A=1,2,3,4 B=5,6,7,8 with noise on in_valid/mm_done; C must be 19,22,43,50
    set_directed();
    compute_c();
    chk("ref_c0", 32'(cur_c[0]), 19);
    chk("ref_c3", 32'(cur_c[3]), 50);
    full_txn(1'b1, 0, 2);

    // Same operands, stalled unload 1,0,0,1
    set_directed();
    full_txn(1'b0, 2, 1);

    // Random transactions
    for (int t = 0; t < 6; t++) begin
      set_random();
      full_txn(($urandom_range(0, 1) == 1), int'($urandom_range(0, 8)), 0);
    end

    // Reset on the third stream cycle, then a fresh load
    set_random();
    compute_c();
    load_phase(1'b0);
    stream_phase(1'b0, 3);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_restart_mm_start", 32'(mm_start), 0);
      chk("no_restart_busy", 32'(busy), 0);
    end
    set_random();
    full_txn(1'b0, 1, 2);

    // Timeout: mm_done never comes
    set_random();
    compute_c();
    load_phase(1'b0);
    stream_phase(1'b0, NE);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("err_before_timeout", 32'(err), 0);
    tick();
    chk("err_at_timeout", 32'(err), 1);
    chk("in_ready_err", 32'(in_ready), 0);
    chk("out_valid_err", 32'(out_valid), 0);
    chk("busy_err", 32'(busy), 1);
    in_valid = 1'b1;
    mm_done  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky", 32'(err), 1);
    chk("in_ready_err_hold", 32'(in_ready), 0);
    in_valid = 1'b0;
    mm_done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("err_reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    set_random();
    full_txn(1'b0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
